// File: rtl/utm_pkg.sv
// utm_pkg: shared symbol constants and one-hot machine-state encoding for the UTM datapath
package utm_pkg;
  localparam int SYM_W = 3;
  localparam logic [SYM_W-1:0] SYM_BLANK = 3'b000;
  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_RUN    = 4'b0010,
    ST_HALTED = 4'b0100,
    ST_FAULT  = 4'b1000
  } state_t;
endpackage

// File: rtl/tape_mem.sv
// tape_mem: TAPE_LEN symbol cells, synchronous write port, asynchronous read port
module tape_mem
  import utm_pkg::*;
#(
  parameter int TAPE_LEN = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        we,
  input  logic [$clog2(TAPE_LEN)-1:0] waddr,
  input  logic [SYM_W-1:0]            wdata,
  input  logic [$clog2(TAPE_LEN)-1:0] raddr,
  output logic [SYM_W-1:0]            rdata
);
  logic [SYM_W-1:0] cells [TAPE_LEN];
  always_ff @(posedge clk)
    if (reset) cells <= '{default: SYM_BLANK};
    else if (we) cells[waddr] <= wdata;
  assign rdata = cells[raddr];
endmodule

// File: rtl/tape_unit.sv
// tape_unit: UTM tape store and head with preload, halt and edge fault.
// Define TAPE_UNIT_WRAP_EN for a circular tape (no edge fault).
module tape_unit
  import utm_pkg::*;
#(
  parameter int TAPE_LEN  = 16,
  parameter int HEAD_INIT = 8,
  parameter int CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load_valid,
  input  logic [SYM_W-1:0]            load_sym,
  input  logic                        start,
  input  logic                        step,
  input  logic [SYM_W-1:0]            z,
  input  logic                        move_left,
  input  logic                        halt,
  output logic                        s2,
  output logic                        s1,
  output logic                        s0,
  output logic [$clog2(TAPE_LEN)-1:0] head_pos,
  output logic                        running,
  output logic                        halted,
  output logic                        fault,
  output logic [CNT_W-1:0]            step_count
);
  localparam int AW = $clog2(TAPE_LEN);
  localparam logic [AW-1:0] HEAD0 = AW'(HEAD_INIT);
  state_t state;
  logic [AW-1:0] load_ptr;
  logic [SYM_W-1:0] sym;
  logic accept;
  assign accept = state == ST_RUN && step;
  // one write port: head during RUN, load pointer during IDLE
  tape_mem #(.TAPE_LEN(TAPE_LEN)) mem (
    .clk  (clk),
    .reset(reset),
    .we   (accept || (state == ST_IDLE && load_valid)),
    .waddr(accept ? head_pos : load_ptr),
    .wdata(accept ? z : load_sym),
    .raddr(head_pos),
    .rdata(sym)
  );
  assign {s2, s1, s0} = sym;
  assign running = state == ST_RUN;
  assign halted  = state == ST_HALTED;
`ifdef TAPE_UNIT_WRAP_EN
  assign fault = 1'b0;
`else
  logic at_edge;
  assign at_edge = move_left ? head_pos == '0 : head_pos == '1;
  assign fault   = state == ST_FAULT;
`endif
  always_ff @(posedge clk)
    if (reset) begin
      state      <= ST_IDLE;
      head_pos   <= HEAD0;
      load_ptr   <= '0;
      step_count <= '0;
    end else if (state == ST_IDLE) begin
      if (load_valid) load_ptr <= load_ptr + 1'b1;
      if (start) begin
        state      <= ST_RUN;
        head_pos   <= HEAD0;
        step_count <= '0;
        load_ptr   <= '0;
      end
    end else if (accept) begin
      step_count <= &step_count ? step_count : step_count + 1'b1;
      if (halt) state <= ST_HALTED;
`ifdef TAPE_UNIT_WRAP_EN
      else head_pos <= move_left ? head_pos - 1'b1 : head_pos + 1'b1;
`else
      else if (at_edge) state <= ST_FAULT;
      else head_pos <= move_left ? head_pos - 1'b1 : head_pos + 1'b1;
`endif
    end
endmodule

// File: tb/tb_tape_unit.sv
// tb_tape_unit: random and directed stimulus against a tape model, checked through a scoreboard queue
module tb_tape_unit;
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2, M_FAULT = 3;
  typedef struct {
    int head;
    int sym;
    int run;
    int hlt;
    int flt;
    int cnt;
  } exp_t;
  logic clk = 0;
  always #5 clk = ~clk;
  logic reset = 1, load_valid = 0, start = 0, step = 0, move_left = 0, halt = 0;
  logic [2:0] load_sym = 0, z = 0;
  logic s2, s1, s0, running, halted, fault;
  logic [3:0] head_pos;
  logic [15:0] step_count;
  logic b_s2, b_s1, b_s0, b_running, b_halted, b_fault;
  logic [3:0] b_head;
  logic [3:0] b_count;
  tape_unit dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_sym(load_sym), .start(start),
    .step(step), .z(z), .move_left(move_left), .halt(halt), .s2(s2), .s1(s1), .s0(s0),
    .head_pos(head_pos), .running(running), .halted(halted), .fault(fault), .step_count(step_count)
  );
  tape_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_sym(load_sym), .start(start),
    .step(step), .z(z), .move_left(move_left), .halt(halt), .s2(b_s2), .s1(b_s1), .s0(b_s0),
    .head_pos(b_head), .running(b_running), .halted(b_halted), .fault(b_fault), .step_count(b_count)
  );
  int tape[16];
  int hd = 8, lp = 0, cnt = 0, st = M_IDLE;
  int checks = 0, errors = 0;
  exp_t q[$];
  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask
  task automatic cyc(input bit r, input bit lv, input int ls, input bit stt, input bit sp,
                     input int zz, input bit ml, input bit h);
    int nh;
    @(negedge clk);
    reset = r; load_valid = lv; load_sym = 3'(ls); start = stt;
    step = sp; z = 3'(zz); move_left = ml; halt = h;
    if (r) begin
      foreach (tape[i]) tape[i] = 0;
      hd = 8; lp = 0; cnt = 0; st = M_IDLE;
    end else if (st == M_IDLE) begin
      if (lv) begin tape[lp] = ls; lp = (lp + 1) % 16; end
      if (stt) begin st = M_RUN; hd = 8; cnt = 0; lp = 0; end
    end else if (st == M_RUN && sp) begin
      tape[hd] = zz;
      cnt++;
      if (h) st = M_HALT;
      else begin
        nh = ml ? hd - 1 : hd + 1;
        if (nh < 0 || nh > 15) begin
`ifdef TAPE_UNIT_WRAP_EN
          hd = (nh + 16) % 16;
`else
          st = M_FAULT;
`endif
        end else hd = nh;
      end
    end
    q.push_back('{head: hd, sym: tape[hd], run: int'(st == M_RUN), hlt: int'(st == M_HALT),
                  flt: int'(st == M_FAULT), cnt: cnt});
  endtask
  task automatic rst_c(); cyc(1, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic ld(input int v); cyc(0, 1, v, 0, 0, 0, 0, 0); endtask
  task automatic go(); cyc(0, 0, 0, 1, 0, 0, 0, 0); endtask
  task automatic stp(input int zz, input bit ml, input bit h); cyc(0, 0, 0, 0, 1, zz, ml, h); endtask
  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("head", int'(head_pos), e.head);
      chk("sym", int'({s2, s1, s0}), e.sym);
      chk("running", int'(running), e.run);
      chk("halted", int'(halted), e.hlt);
      chk("fault", int'(fault), e.flt);
      chk("count", int'(step_count), e.cnt > 65535 ? 65535 : e.cnt);
      chk("count4", int'(b_count), e.cnt > 15 ? 15 : e.cnt);
    end
  end
  initial begin
    int b;
    rst_c(); rst_c();
    ld(1); ld(2); ld(4); ld(5);
    repeat (12) ld(0);
    ld(3);
    go();
    stp(5, 0, 0);
    stp(2, 1, 0);
    repeat (8) stp($urandom % 8, 1, 0);
    stp(1, 1, 0);
    repeat (3) stp($urandom % 8, $urandom % 2 == 1, 0);
    rst_c(); go();
    stp(6, 0, 0);
    cyc(1, 0, 0, 0, 1, 7, 0, 0);
    go();
    stp(4, 0, 1);
    repeat (3) stp($urandom % 8, 0, 0);
    rst_c(); go();
    repeat (7) stp($urandom % 8, 0, 0);
    stp(3, 0, 0);
    repeat (2) stp($urandom % 8, 0, 0);
    rst_c(); go();
    for (int i = 0; i < 20; i++) stp($urandom % 8, i % 2 == 1, 0);
    repeat (25) begin
      rst_c();
      repeat ($urandom % 20) ld($urandom % 8);
      go();
      repeat (40)
        cyc($urandom % 60 == 0, $urandom % 4 == 0, $urandom % 8, $urandom % 8 == 0,
            $urandom % 10 < 7, $urandom % 8, $urandom % 2 == 1, $urandom % 20 == 0);
    end
    b = 0;
    while (q.size() > 0 && b < 10) begin @(posedge clk); b++; end
    #2;
    if (q.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
